// File: rtl/cellram_burst_responder_if.sv
// Control/handshake signals of the synchronous burst CellularRAM bus.
// DQ is a shared tristate bus and is kept as a plain inout on the device.
interface cellram_burst_responder_if;
  logic        CE_n;
  logic        ADV_n;
  logic        WE_n;
  logic        OE_n;
  logic        LB_n;
  logic        UB_n;
  logic        CRE;
  logic [19:0] Addr;
  logic        WAIT;

  modport master (output CE_n, ADV_n, WE_n, OE_n, LB_n, UB_n, CRE, Addr, input WAIT);
  modport slave  (input  CE_n, ADV_n, WE_n, OE_n, LB_n, UB_n, CRE, Addr, output WAIT);
endinterface

// File: rtl/cellram_burst_responder.sv
// Device-side burst CellularRAM model backed by an internal word memory.
// Optional BCR (configurable latency, CRE accesses) with CELLRAM_RESP_BCR_EN.
module cellram_burst_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  cellram_burst_responder_if.slave     bus,
  inout  wire  [15:0]                  DQ
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LAT   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CFG   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [15:0]       dout_q;
  logic [15:0]       mem [0:(1<<ADDR_W)-1];
  logic [2:0]        lat_eff;
  logic              lat_done, rd_adv, wr_en;
  logic              dq_oe;
  logic [15:0]       dq_out;
  logic              unused_addr;

  assign unused_addr = ^bus.Addr;

`ifdef CELLRAM_RESP_BCR_EN
  logic [15:0] bcr_q, bcr_d;
  assign lat_eff = (bcr_q[13:11] == 3'd0) ? 3'd1 : bcr_q[13:11];
  assign dq_out  = (state_q == S_CFG) ? bcr_q : dout_q;
`else
  assign lat_eff = 3'(LATENCY);
  assign dq_out  = dout_q;
`endif

  // cnt_q holds edges seen since E0 minus one, so the L-th edge ends latency
  assign lat_done = (cnt_q + 3'd1) == lat_eff;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    rd_adv  = 1'b0;
    wr_en   = 1'b0;
`ifdef CELLRAM_RESP_BCR_EN
    bcr_d   = bcr_q;
`endif
    if (bus.CE_n) begin
      state_d = S_IDLE;
    end else if (!bus.ADV_n) begin
      // new address wins over continuing any burst in flight
      addr_d = bus.Addr[ADDR_W-1:0];
      we_d   = bus.WE_n;
      cnt_d  = 3'd0;
      if (!bus.CRE) begin
        state_d = S_LAT;
      end else begin
`ifdef CELLRAM_RESP_BCR_EN
        if (!bus.WE_n) begin
          bcr_d   = bus.Addr[15:0];
          state_d = S_IDLE;
        end else begin
          state_d = S_CFG;
        end
`else
        state_d = S_IDLE;
`endif
      end
    end else begin
      case (state_q)
        S_LAT: begin
          if (lat_done) begin
            state_d = we_q ? S_READ : S_WRITE;
            rd_adv  = we_q;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_READ:  rd_adv = 1'b1;
        S_WRITE: wr_en  = 1'b1;
        S_CFG:   cnt_d  = 3'd1;
        default: ;
      endcase
    end
    if (rd_adv || wr_en) addr_d = addr_q + ADDR_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

`ifdef CELLRAM_RESP_BCR_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) bcr_q <= 16'h9D1F;
    else        bcr_q <= bcr_d;
  end
`endif

  // memory survives reset; wr_en is low whenever reset holds the FSM idle
  always_ff @(posedge CLK) begin
    if (rd_adv) dout_q <= mem[addr_q];
    if (wr_en) begin
      if (!bus.LB_n) mem[addr_q][7:0]  <= DQ[7:0];
      if (!bus.UB_n) mem[addr_q][15:8] <= DQ[15:8];
    end
  end

  assign dq_oe    = ((state_q == S_READ) || (state_q == S_CFG && cnt_q != 3'd0)) && !bus.OE_n;
  assign DQ       = dq_oe ? dq_out : {16{1'bz}};
  assign bus.WAIT = (state_q == S_LAT);

endmodule

// File: doc/cellram_burst_responder.md
Name: cellram_burst_responder

Overview:
- Synthesizable device-side (responder) model of the synchronous burst CellularRAM interface that the BurstMode controller drives.
- Backed by an internal word memory, so controller-initiated bursts can run on FPGA without external PSRAM, and in simulation without the vendor behavioural model.
- Decodes CE_n/ADV_n/WE_n/OE_n/LB_n/UB_n/CRE, generates WAIT, and sources or sinks data on the shared 16-bit DQ bus.

Parameters:
- ADDR_W, 10: internal memory address width (2^ADDR_W 16-bit words); Addr bits above ADDR_W-1 are ignored.
- LATENCY, 3: initial access latency in clocks (legal range 1..7); used as the effective latency when the BCR feature is compiled out.

Ports:
- CLK  in  1  interface clock; all sampling on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CE_n  in  1  chip enable, active low.
- ADV_n  in  1  address valid, active low.
- WE_n  in  1  write enable, active low, sampled with the address.
- OE_n  in  1  output enable, active low; gates the DQ drive.
- LB_n  in  1  lower byte enable, active low.
- UB_n  in  1  upper byte enable, active low.
- CRE  in  1  configuration register enable, sampled with the address.
- Addr  in  20  word address.
- WAIT  out  1  active-high wait; high while data is not yet valid.
- DQ  inout  16  data bus; driven only in READ or CFG_RD with OE_n=0, otherwise high-Z.

Behaviour:
- Reset (async, RST_N=0): state IDLE; WAIT=0; DQ high-Z; burst address=0; latency counter=0. Memory contents are not cleared.
- States: IDLE, LAT, READ, WRITE, CFG_RD.
- Access start: at a rising edge E0 with CE_n=0 and ADV_n=0:
  - Capture Addr[ADDR_W-1:0], WE_n and CRE.
  - CRE=0: go to LAT, WAIT=1 after E0.
  - CRE=1: handled per Optional Feature.
- LAT:
  - The counter counts edges after E0.
  - At edge E_L (L = effective latency): WAIT<=0; enter READ if the captured WE_n=1, else WRITE.
- READ:
  - After E_L, DQ carries mem[A]; after E_(L+k), DQ carries mem[A+k].
  - Continuous burst; address increments modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0).
  - LB_n/UB_n do not mask read data.
- WRITE:
  - Word k is sampled at edge E_(L+1+k) into address A+k, same wrap rule.
  - Byte lanes are written only where LB_n=0 (DQ[7:0]) or UB_n=0 (DQ[15:8]).
  - Both enables high: the address still advances but nothing is written.
- Burst end:
  - Any edge with CE_n=1 returns the state to IDLE; WAIT=0 and DQ is released after that edge.
  - A write edge that samples CE_n=1 does not write.
- Re-address: ADV_n=0 with CE_n=0 in any non-IDLE state aborts the current burst and restarts at E0 with the new address. This takes precedence over continuing the burst.
- Reset asserted mid-burst: immediate IDLE, DQ high-Z; no further memory writes.
- WAIT is 0 in IDLE, READ, WRITE and CFG_RD.

Optional Feature:
- Macro: CELLRAM_RESP_BCR_EN.
- Defined:
  - A 16-bit BCR exists, reset to 16'h9D1F; effective latency = BCR[13:11].
  - Value 0 in BCR[13:11] is treated as 1.
  - CRE=1 with WE_n=0 at E0 writes BCR<=Addr[15:0]; state returns to IDLE with no WAIT.
  - CRE=1 with WE_n=1 at E0 enters CFG_RD: BCR is driven on DQ after E1 while OE_n=0, then IDLE at the first edge with CE_n=1.
  - A BCR write takes effect for the next access.
- Undefined:
  - No BCR; effective latency = LATENCY.
  - CRE=1 accesses are ignored: the state stays IDLE, WAIT=0 and DQ high-Z.

Test Plan:
- Reset with RST_N=0 mid-READ -> DQ goes high-Z and WAIT=0 without waiting for a clock edge; after release, state is IDLE and prior memory contents are retained.
- Write burst at A=0x005, LATENCY=3, data 0x1111, 0x2222, 0x3333 at E4..E6, LB_n=UB_n=0; then read burst at 0x005:
  - Write phase: WAIT high after E0..E2, low after E3.
  - Read phase: DQ = 0x1111, 0x2222, 0x3333 after E3..E5.
- Byte-lane write of 0xABCD at address 0x010 (previously 0x0000), UB_n=1, LB_n=0 -> readback 0x00CD.
- Read burst starting at 0x3FE (ADDR_W=10), 4 words -> data from 0x3FE, 0x3FF, 0x000, 0x001.
- CE_n raised after the 2nd read word, then a new access with ADV_n=0 at 0x020 two cycles later -> DQ high-Z in between; the new access shows full latency and returns mem[0x020].
- With CELLRAM_RESP_BCR_EN:
  - CRE write with Addr=0x8D1F (latency 1), then a read at 0x005 -> first data after E1.
  - A CRE read -> DQ=0x8D1F.
